// File: rtl/approx_error_monitor_if.sv
// Handshake/result bundle between the error monitor and its environment.
// Carries the sweep control, the vector to the approximate DUT, its response and the results.
// master drives start and the DUT response; slave is the monitor itself.
interface approx_error_monitor_if #(
    parameter int IN_W  = 4,
    parameter int OUT_W = 3
);
    logic              start;
    logic [IN_W-1:0]   approx_in;
    logic [OUT_W-1:0]  approx_out;
    logic              busy;
    logic              done;
    logic [OUT_W-1:0]  max_err;
    logic [IN_W:0]     err_count;
    logic [IN_W-1:0]   worst_vec;
    logic              violation;

    modport master (
        output start,
        output approx_out,
        input  approx_in,
        input  busy,
        input  done,
        input  max_err,
        input  err_count,
        input  worst_vec,
        input  violation
    );

    modport slave (
        input  start,
        input  approx_out,
        output approx_in,
        output busy,
        output done,
        output max_err,
        output err_count,
        output worst_vec,
        output violation
    );
endinterface

// File: rtl/approx_error_monitor.sv
// Exhaustive sweep checker: drives every vector into a combinational approx abs_diff and scores it against exact |a-b|.
// Latency: one vector per cycle, 2^IN_W cycles per sweep; results valid when done rises.
// Backpressure: none; start is honoured only in IDLE/DONE and ignored while sweeping.
module approx_error_monitor #(
    parameter int IN_W  = 4,
    parameter int OUT_W = 3,
    parameter int ET    = 4
) (
    input logic                  clk,
    input logic                  rst_n,
    approx_error_monitor_if.slave bus
);
    localparam int OP_W = IN_W / 2;
    // One extra bit so the threshold compare never truncates ET.
    localparam logic [OUT_W:0] ET_CMP = (OUT_W + 1)'(ET);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_q,     state_d;
    logic [IN_W-1:0]  approx_in_q, approx_in_d;
    logic [OUT_W-1:0] max_err_q,   max_err_d;
    logic [IN_W:0]    err_count_q, err_count_d;
    logic [IN_W-1:0]  worst_vec_q, worst_vec_d;
    logic             violation_q, violation_d;
    logic             busy_q,      busy_d;
    logic             done_q,      done_d;

    logic [OP_W-1:0]  op_a;
    logic [OP_W-1:0]  op_b;
    logic [OP_W-1:0]  exact_op;
    logic [OUT_W-1:0] exact;
    logic [OUT_W-1:0] err;
    logic             last_vec;

    // Reference |a-b| and the error of the approximate response for the current vector.
    always_comb begin
        op_a     = approx_in_q[OP_W-1:0];
        op_b     = approx_in_q[IN_W-1:OP_W];
        exact_op = (op_a >= op_b) ? (op_a - op_b) : (op_b - op_a);
        exact    = OUT_W'(exact_op);
        err      = (exact >= bus.approx_out) ? (exact - bus.approx_out)
                                             : (bus.approx_out - exact);
        last_vec = &approx_in_q;
    end

    // Next-state and statistics update; a fresh start clears all results.
    always_comb begin
        state_d     = state_q;
        approx_in_d = approx_in_q;
        max_err_d   = max_err_q;
        err_count_d = err_count_q;
        worst_vec_d = worst_vec_q;
        violation_d = violation_q;
        busy_d      = busy_q;
        done_d      = done_q;
        case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    state_d     = SWEEP;
                    approx_in_d = '0;
                    max_err_d   = '0;
                    err_count_d = '0;
                    worst_vec_d = '0;
                    violation_d = 1'b0;
                    busy_d      = 1'b1;
                    done_d      = 1'b0;
                end
            end
            SWEEP: begin
                if (err != '0) begin
                    err_count_d = err_count_q + (IN_W + 1)'(1);
                end
                // Strictly greater: on a tie the earlier vector stays the worst.
                if (err > max_err_q) begin
                    max_err_d   = err;
                    worst_vec_d = approx_in_q;
                end
                if ({1'b0, err} > ET_CMP) begin
                    violation_d = 1'b1;
                end
                // Wraps to 0 after the last vector, so DONE presents vector 0.
                approx_in_d = approx_in_q + IN_W'(1);
                if (last_vec) begin
                    state_d = DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and all registered outputs; reset drops any partial sweep.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            approx_in_q <= '0;
            max_err_q   <= '0;
            err_count_q <= '0;
            worst_vec_q <= '0;
            violation_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            approx_in_q <= approx_in_d;
            max_err_q   <= max_err_d;
            err_count_q <= err_count_d;
            worst_vec_q <= worst_vec_d;
            violation_q <= violation_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign bus.approx_in = approx_in_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.max_err   = max_err_q;
    assign bus.err_count = err_count_q;
    assign bus.worst_vec = worst_vec_q;
    assign bus.violation = violation_q;
endmodule
